// File: rtl/inv_sbox_iter_if.sv
// Byte stream bundle for the iterative AES inverse S-box.
//
// Handshake rules, identical on both sides: a transfer happens on a rising
// edge where valid and ready are both high. A source that raises valid keeps
// valid and its data stable until that transfer. A sink may drive ready
// without waiting for valid. Here in_ready depends only on the block state
// and out_ready, never on in_valid.
//
// dbg_state encoding: 0 = IDLE, 1 = COMP, 2 = DONE.
// dbg_cnt is the square-and-multiply step counter.
interface inv_sbox_iter_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic [1:0] dbg_state;
  logic [2:0] dbg_cnt;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, dbg_state, dbg_cnt
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, dbg_state, dbg_cnt
  );
endinterface

// File: rtl/inv_sbox_iter.sv
// Iterative AES inverse S-box: out = (InvAffine(in))^254 over GF(2^8), 0x11B.
// One square-and-multiply per cycle, one byte in flight. Accepting at edge E
// makes the result visible after edge E+7. With ZERO_LAT_ACCEPT set, a new
// byte can be taken on the same edge as the output handshake.
module inv_sbox_iter #(
  parameter logic [7:0] INV_AFF_CONST   = 8'h05,
  parameter bit         ZERO_LAT_ACCEPT = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  inv_sbox_iter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COMP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Steps 0..5 build x^3 .. x^127 with square-then-multiply. Step 6 is a
  // plain square, which gives x^254.
  localparam logic [2:0] LAST_MUL_STEP = 3'd6;

  // Multiply by x with reduction. The bit leaving position 7 folds back as 0x1B.
  function automatic logic [7:0] gf_xtime(input logic [7:0] v);
    gf_xtime = {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

  // Shift-and-add multiply. Every intermediate value stays 8 bits wide.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    gf_mul = acc;
  endfunction

  function automatic logic [7:0] gf_sq(input logic [7:0] x);
    gf_sq = gf_mul(x, x);
  endfunction

  // Output bit i XORs input bits i+2, i+5 and i+7 (mod 8). These are left
  // rotations by 6, 3 and 1.
  function automatic logic [7:0] inv_affine(input logic [7:0] d);
    inv_affine = {d[1:0], d[7:2]} ^ {d[4:0], d[7:5]} ^ {d[6:0], d[7]} ^ INV_AFF_CONST;
  endfunction

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] r_q, r_d;
  logic [7:0] a_q, a_d;

  logic       in_ready_w;
  logic       in_hs;
  logic [7:0] a_new;
  logic [7:0] sq_r;

  assign a_new = inv_affine(bus.in_data);
  assign sq_r  = gf_sq(r_q);

  // DONE only offers ready when the held result is leaving on this same edge.
  assign in_ready_w = (state_q == ST_IDLE) |
                      (ZERO_LAT_ACCEPT & (state_q == ST_DONE) & bus.out_ready);
  assign in_hs      = bus.in_valid & in_ready_w;

  // Register update. Reset discards any byte that is still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      r_q     <= 8'h00;
      a_q     <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      a_q     <= a_d;
    end
  end

  // Next state: load on accept, run the power chain, hold the result until it is taken.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    a_d     = a_q;
    case (state_q)
      ST_IDLE: begin
        if (in_hs) begin
          a_d     = a_new;
          r_d     = a_new;
          cnt_d   = 3'd0;
          state_d = ST_COMP;
        end
      end
      ST_COMP: begin
        if (cnt_q < LAST_MUL_STEP) begin
          r_d   = gf_mul(sq_r, a_q);
          cnt_d = cnt_q + 3'd1;
        end else begin
          r_d     = sq_r;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          if (in_hs) begin
            a_d     = a_new;
            r_d     = a_new;
            cnt_d   = 3'd0;
            state_d = ST_COMP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_data  = (state_q == ST_DONE) ? r_q : 8'h00;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.dbg_state = state_q;
  assign bus.dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_inv_sbox_iter.sv
// Bench for inv_sbox_iter. dut1 uses ZERO_LAT_ACCEPT=1 and dut0 uses 0.
// Both DUTs share one driver. The sel signal steers the driver and the monitor
// to one DUT. The DUT that is not selected gets in_valid=0 and out_ready=1.
module tb_inv_sbox_iter;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_COMP = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_sbox_iter_if b1 ();
  inv_sbox_iter_if b0 ();

  inv_sbox_iter #(.INV_AFF_CONST(8'h05), .ZERO_LAT_ACCEPT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  inv_sbox_iter #(.INV_AFF_CONST(8'h05), .ZERO_LAT_ACCEPT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
  );

  logic       sel;
  logic       drv_in_valid;
  logic       drv_out_ready;
  logic [7:0] drv_in_data;

  assign b1.in_valid  = sel & drv_in_valid;
  assign b1.in_data   = drv_in_data;
  assign b1.out_ready = sel ? drv_out_ready : 1'b1;
  assign b0.in_valid  = ~sel & drv_in_valid;
  assign b0.in_data   = drv_in_data;
  assign b0.out_ready = sel ? 1'b1 : drv_out_ready;

  logic       mon_in_ready, mon_out_valid, mon_busy;
  logic [7:0] mon_out_data;
  logic [1:0] mon_state;
  logic [2:0] mon_cnt;

  assign mon_in_ready  = sel ? b1.in_ready  : b0.in_ready;
  assign mon_out_valid = sel ? b1.out_valid : b0.out_valid;
  assign mon_out_data  = sel ? b1.out_data  : b0.out_data;
  assign mon_busy      = sel ? b1.busy      : b0.busy;
  assign mon_state     = sel ? b1.dbg_state : b0.dbg_state;
  assign mon_cnt       = sel ? b1.dbg_cnt   : b0.dbg_cnt;

  logic [7:0] exp_q[$];
  int         acc_q[$];

  // ---------------- reference model ----------------
  // Carry-less integer product, then reduction modulo 0x11B.
  function automatic logic [7:0] ref_gmul(input logic [7:0] x, input logic [7:0] y);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (y[i]) p = p ^ (int'(x) << i);
    for (int b = 14; b >= 8; b--) if (p[b]) p = p ^ (int'(32'h11B) << (b - 8));
    return p[7:0];
  endfunction

  // Multiplicative inverse found by search. 0 maps to 0.
  function automatic logic [7:0] ref_inv(input logic [7:0] x);
    if (x == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++) if (ref_gmul(x, 8'(y)) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction

  function automatic logic [7:0] ref_rotl(input logic [7:0] d, input int k);
    logic [15:0] t;
    t = {d, d} << k;
    return t[15:8];
  endfunction

  function automatic logic [7:0] ref_invsbox(input logic [7:0] d);
    return ref_inv(ref_rotl(d, 1) ^ ref_rotl(d, 3) ^ ref_rotl(d, 6) ^ 8'h05);
  endfunction

  // ---------------- driver ----------------
  // Sends one byte with out_ready held by the caller. Returns the result, the
  // accept edge, and the first edge after which out_valid was seen.
  task automatic xfer(input logic [7:0] d, output logic [7:0] q, output int acc,
                      output int first, output bit to);
    int n;
    to = 1'b0;
    @(negedge clk);
    drv_in_data  = d;
    drv_in_valid = 1'b1;
    #1;
    n = 0;
    while (!mon_in_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!mon_in_ready) to = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    drv_in_valid = 1'b0;
    #1;
    n = 0;
    while (!mon_out_valid && n < 20) begin @(negedge clk); #1; n++; end
    if (!mon_out_valid) to = 1'b1;
    first = cyc;
    q     = mon_out_data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sel = 1'b1; drv_in_valid = 1'b0; drv_out_ready = 1'b0; drv_in_data = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #1;
      checks++; if (mon_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut%0d: got %b expected 0", s, mon_out_valid); end
      checks++; if (mon_out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data dut%0d: got %h expected 00", s, mon_out_data); end
      checks++; if (mon_busy !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: got %b expected 0", s, mon_busy); end
      checks++; if (mon_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready dut%0d: got %b expected 1", s, mon_in_ready); end
      checks++; if (mon_state !== ST_IDLE) begin errors++; $display("FAIL reset_state dut%0d: got %0d expected %0d", s, mon_state, ST_IDLE); end
      checks++; if (mon_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt dut%0d: got %0d expected 0", s, mon_cnt); end
    end
    sel = 1'b1;
    rst = 1'b0;
  endtask

  task automatic test_latency();
    logic [7:0] q; int acc, first; bit to;
    sel = 1'b1; drv_out_ready = 1'b1;
    xfer(8'h63, q, acc, first, to);
    checks++; if (to) begin errors++; $display("FAIL latency_timeout: got timeout expected result"); end
    checks++; if (first != acc + 7) begin errors++; $display("FAIL latency_cycles: got %0d expected %0d", first - acc, 7); end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL latency_data 63: got %h expected 00", q); end
    checks++; if (mon_busy !== 1'b1) begin errors++; $display("FAIL latency_busy_done: got %b expected 1", mon_busy); end
    @(negedge clk); #1;
    checks++; if (mon_busy !== 1'b0) begin errors++; $display("FAIL latency_busy_after: got %b expected 0", mon_busy); end
    checks++; if (mon_out_valid !== 1'b0) begin errors++; $display("FAIL latency_valid_after: got %b expected 0", mon_out_valid); end
  endtask

  task automatic test_vectors();
    logic [7:0] vin [5];
    logic [7:0] vout[5];
    logic [7:0] q; int acc, first; bit to;
    vin  = '{8'h00, 8'h01, 8'h7C, 8'hFF, 8'h16};
    vout = '{8'h52, 8'h09, 8'h01, 8'h7D, 8'hFF};
    sel = 1'b1; drv_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      xfer(vin[i], q, acc, first, to);
      checks++; if (to || q !== vout[i]) begin errors++; $display("FAIL vector %h: got %h expected %h (timeout=%0b)", vin[i], q, vout[i], to); end
    end
  endtask

  task automatic test_exhaustive();
    int nxt, got, guard; bit prev_ov, pend, hs; logic [7:0] e; int a;
    nxt = 0; got = 0; guard = 0; prev_ov = 1'b0; pend = 1'b0;
    sel = 1'b1; drv_out_ready = 1'b1; drv_in_valid = 1'b0;
    exp_q.delete(); acc_q.delete();
    @(negedge clk);
    while (got < 256 && guard < 3000) begin
      if (pend) begin nxt++; pend = 1'b0; end
      drv_in_valid = (nxt < 256);
      drv_in_data  = nxt[7:0];
      #1;
      if (mon_out_valid && !prev_ov && acc_q.size() > 0) begin
        checks++; if (cyc != acc_q[0] + 7) begin errors++; $display("FAIL exh_latency: got %0d expected 7", cyc - acc_q[0]); end
      end
      prev_ov = mon_out_valid;
      hs = mon_out_valid && drv_out_ready;
      if (hs) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL exh_unexpected_output: got %h expected none", mon_out_data); end
        else begin
          e = exp_q.pop_front(); a = acc_q.pop_front();
          if (mon_out_data !== e) begin errors++; $display("FAIL exh_data #%0d: got %h expected %h", got, mon_out_data, e); end
        end
        got++;
      end
      if (drv_in_valid && mon_in_ready) begin
        if (nxt > 0) begin
          checks++; if (!hs) begin errors++; $display("FAIL exh_zero_lat_accept: got accept without handshake expected same edge"); end
        end
        exp_q.push_back(ref_invsbox(nxt[7:0]));
        acc_q.push_back(cyc + 1);
        pend = 1'b1;
      end
      @(negedge clk); guard++;
    end
    drv_in_valid = 1'b0;
    checks++; if (got != 256) begin errors++; $display("FAIL exh_timeout: got %0d results expected 256", got); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    int sent, got, guard, n_tot; bit prev_ov, prev_stall, pend, hs;
    logic [7:0] prev_d, cur, e; int a;
    n_tot = 40; sent = 0; got = 0; guard = 0;
    prev_ov = 1'b0; prev_stall = 1'b0; pend = 1'b0; prev_d = 8'h00;
    sel = 1'b1; drv_in_valid = 1'b0;
    exp_q.delete(); acc_q.delete();
    cur = 8'($urandom_range(0, 255));
    @(negedge clk);
    while (got < n_tot && guard < 2000) begin
      if (pend) begin sent++; pend = 1'b0; cur = 8'($urandom_range(0, 255)); drv_in_valid = 1'b0; end
      if (!drv_in_valid && sent < n_tot) drv_in_valid = ($urandom_range(0, 2) != 0);
      drv_in_data   = cur;
      drv_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (prev_stall) begin
        checks++;
        if (!mon_out_valid || mon_out_data !== prev_d) begin errors++; $display("FAIL rnd_stall_hold: got valid=%b data=%h expected valid=1 data=%h", mon_out_valid, mon_out_data, prev_d); end
      end
      if (mon_out_valid && !prev_ov && acc_q.size() > 0) begin
        checks++; if (cyc != acc_q[0] + 7) begin errors++; $display("FAIL rnd_latency: got %0d expected 7", cyc - acc_q[0]); end
      end
      prev_ov    = mon_out_valid;
      hs         = mon_out_valid && drv_out_ready;
      prev_stall = mon_out_valid && !drv_out_ready;
      prev_d     = mon_out_data;
      if (hs) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_unexpected_output: got %h expected none", mon_out_data); end
        else begin
          e = exp_q.pop_front(); a = acc_q.pop_front();
          if (mon_out_data !== e) begin errors++; $display("FAIL rnd_data #%0d: got %h expected %h", got, mon_out_data, e); end
        end
        got++;
      end
      if (drv_in_valid && mon_in_ready) begin
        exp_q.push_back(ref_invsbox(cur));
        acc_q.push_back(cyc + 1);
        pend = 1'b1;
      end
      @(negedge clk); guard++;
    end
    drv_in_valid = 1'b0; drv_out_ready = 1'b1;
    checks++; if (got != n_tot) begin errors++; $display("FAIL rnd_timeout: got %0d results expected %0d", got, n_tot); end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_stall();
    int n; bit to;
    sel = 1'b1; drv_out_ready = 1'b0;
    @(negedge clk);
    drv_in_data = 8'h00; drv_in_valid = 1'b1;
    @(negedge clk);
    drv_in_valid = 1'b0;
    #1;
    n = 0;
    while (!mon_out_valid && n < 20) begin @(negedge clk); #1; n++; end
    to = !mon_out_valid;
    checks++; if (to) begin errors++; $display("FAIL stall_timeout: got no output expected 52"); end
    drv_in_data = 8'hAA; drv_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++; if (mon_out_valid !== 1'b1 || mon_out_data !== 8'h52) begin errors++; $display("FAIL stall_hold cycle %0d: got valid=%b data=%h expected valid=1 data=52", i, mon_out_valid, mon_out_data); end
      checks++; if (mon_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cycle %0d: got %b expected 0", i, mon_in_ready); end
      checks++; if (mon_state !== ST_DONE) begin errors++; $display("FAIL stall_state cycle %0d: got %0d expected %0d", i, mon_state, ST_DONE); end
      @(negedge clk);
    end
    drv_in_valid = 1'b0; drv_out_ready = 1'b1;
    #1;
    checks++; if (mon_out_data !== 8'h52) begin errors++; $display("FAIL stall_release_data: got %h expected 52", mon_out_data); end
    @(negedge clk); #1;
    checks++; if (mon_state !== ST_IDLE || mon_out_valid !== 1'b0) begin errors++; $display("FAIL stall_after_release: got state=%0d valid=%b expected state=0 valid=0", mon_state, mon_out_valid); end
  endtask

  task automatic test_reset_mid();
    int n; bit seen;
    sel = 1'b1; drv_out_ready = 1'b1;
    @(negedge clk);
    drv_in_data = 8'h7C; drv_in_valid = 1'b1;
    @(negedge clk);
    drv_in_valid = 1'b0;
    #1;
    n = 0;
    while (!(mon_state == ST_COMP && mon_cnt == 3'd3) && n < 20) begin @(negedge clk); #1; n++; end
    checks++; if (mon_cnt !== 3'd3) begin errors++; $display("FAIL rstmid_reach_cnt3: got %0d expected 3", mon_cnt); end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (mon_state !== ST_IDLE) begin errors++; $display("FAIL rstmid_state: got %0d expected %0d", mon_state, ST_IDLE); end
    checks++; if (mon_out_valid !== 1'b0 || mon_busy !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got valid=%b busy=%b expected 0 0", mon_out_valid, mon_busy); end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin @(negedge clk); #1; if (mon_out_valid) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL rstmid_ghost_output: got out_valid=1 expected none"); end
  endtask

  task automatic test_back_to_back();
    int sent, got, guard, n_tot, last_hs; bit prev_ov, pend, hs;
    logic [7:0] cur, e; int a;
    n_tot = 6; sent = 0; got = 0; guard = 0; last_hs = -100;
    prev_ov = 1'b0; pend = 1'b0;
    sel = 1'b0; drv_out_ready = 1'b1; drv_in_valid = 1'b0;
    exp_q.delete(); acc_q.delete();
    cur = 8'($urandom_range(0, 255));
    @(negedge clk);
    while (got < n_tot && guard < 400) begin
      if (pend) begin sent++; pend = 1'b0; cur = 8'($urandom_range(0, 255)); end
      drv_in_valid = (sent < n_tot);
      drv_in_data  = cur;
      #1;
      if (mon_out_valid) begin
        checks++; if (mon_in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_done: got %b expected 0", mon_in_ready); end
      end
      if (mon_out_valid && !prev_ov && acc_q.size() > 0) begin
        checks++; if (cyc != acc_q[0] + 7) begin errors++; $display("FAIL b2b_latency: got %0d expected 7", cyc - acc_q[0]); end
      end
      prev_ov = mon_out_valid;
      hs = mon_out_valid && drv_out_ready;
      if (hs) begin
        last_hs = cyc + 1;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_unexpected_output: got %h expected none", mon_out_data); end
        else begin
          e = exp_q.pop_front(); a = acc_q.pop_front();
          if (mon_out_data !== e) begin errors++; $display("FAIL b2b_data #%0d: got %h expected %h", got, mon_out_data, e); end
        end
        got++;
      end
      if (drv_in_valid && mon_in_ready) begin
        if (sent > 0) begin
          checks++; if (cyc + 1 != last_hs + 1) begin errors++; $display("FAIL b2b_accept_gap: got %0d expected 1", cyc + 1 - last_hs); end
        end
        exp_q.push_back(ref_invsbox(cur));
        acc_q.push_back(cyc + 1);
        pend = 1'b1;
      end
      @(negedge clk); guard++;
    end
    drv_in_valid = 1'b0;
    checks++; if (got != n_tot) begin errors++; $display("FAIL b2b_timeout: got %0d results expected %0d", got, n_tot); end
    repeat (2) @(negedge clk);
    sel = 1'b1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_exhaustive();
    test_random();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got time limit expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
